nx_fifo_drain: RTL and testbench
================================

// Module: nx_fifo_drain
// PURPOSE
//  Read-side companion of nx_fifo: owns the FIFO read port (empty/rdata/ren) and converts it into a
//  registered valid/ready stream for downstream pipelines. A 2-entry output buffer sustains 1 beat/clk.
//  There is no combinational path from out_ready to fifo_ren or to out_data.
//  Sits between any nx_fifo instance and its consumer in the same clock domain.
// PARAMETERS
//  WIDTH      128  data width; must match the connected nx_fifo WIDTH
//  CNT_WIDTH  16   width of the delivered-beat statistics counter
// PORTS
//  clk          in   1          single clock; all logic is posedge clk
//  rst          in   1          synchronous reset, active-high
//  flush        in   1          sync discard of buffered beats; tie to the same source as nx_fifo clear
//  fifo_empty   in   1          nx_fifo empty
//  fifo_rdata   in   WIDTH      nx_fifo rdata (show-ahead; valid in the same cycle as !fifo_empty)
//  fifo_ren     out  1          nx_fifo ren
//  out_valid    out  1          head beat valid
//  out_ready    in   1          consumer accepts head beat
//  out_data     out  WIDTH      head beat data
//  occupancy    out  2          beats held in the buffer (0..2)
//  beat_cnt     out  CNT_WIDTH  beats delivered (out_valid & out_ready); saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - occupancy=0, out_valid=0, out_data=0, beat_cnt=0.
//   - fifo_ren=0 while rst is high.
//  Buffer state
//   - occ in {0,1,2}; entries e0 (head) and e1, kept in FIFO order.
//   - out_valid = (occ!=0); out_data = e0, or 0 when occ=0.
//  Read request
//   - fifo_ren = !rst & !flush & !fifo_empty & (occ<2). This is combinational from registered state and inputs only.
//   - When fifo_ren=1, fifo_rdata is captured at the same posedge.
//  Per-cycle update: push = fifo_ren, pop = out_valid & out_ready
//   - push & !pop: write to e[occ]; occ+1.
//   - pop & !push: e0<=e1; occ-1.
//   - push & pop: if occ=1, e0<=fifo_rdata; if occ=2, e0<=e1 and e1<=fifo_rdata (occ=2 cannot push, listed for completeness).
//   - occ is unchanged in this case.
//  Transitions
//   - S0 -push-> S1.
//   - S1 -push&!pop-> S2; S1 -pop&!push-> S0; S1 -push&pop-> S1.
//   - S2 -pop-> S1. S2 never pushes.
//  Latency and throughput
//   - Entry visible at fifo head at cycle t produces out_valid at t+1.
//   - Steady stream with out_ready=1: one beat/clk, occ stays 1.
//  Handshake rules
//   - Once out_valid=1, out_valid and out_data stay stable until the pop, except on flush or rst.
//   - After a stall, the first beat popped when out_ready returns is the oldest beat (no reordering).
//  Flush
//   - Priority over push and pop; no pop counted in that cycle.
//   - occ<=0, out_valid<=0, out_data<=0, fifo_ren=0.
//   - beat_cnt is retained.
//  beat_cnt
//   - +1 per pop; holds at 2^CNT_WIDTH-1 (no wrap).
//  Boundaries
//   - fifo_empty=1: no ren (nx_fifo underflow can never be caused by this block).
//   - rst mid-stream: buffered beats are dropped; undelivered FIFO content stays in nx_fifo.
// TESTING
//  T1 Reset
//   - 3 entries A,B,C in fifo, out_ready=1 -> out_valid 1 cycle after first ren.
//   - Beats A,B,C on 3 consecutive clks; beat_cnt=3; fifo_ren high for exactly 3 cycles.
//  T2 Backpressure
//   - out_ready=0 with fifo holding 4 entries -> exactly 2 rens; occupancy=2; out_data=first entry held stable.
//   - Raise out_ready -> 4 beats in order, 1/clk after the first.
//  T3 Alternating out_ready (1,0,1,0...) over 8 entries
//   - 8 beats, in order, none lost or duplicated.
//   - Every out_valid&!out_ready cycle keeps out_data stable.
//  T4 Flush with occupancy=2 and fifo non-empty
//   - Next cycle: out_valid=0, occupancy=0, fifo_ren=0 during flush.
//   - beat_cnt unchanged; the stream resumes with the next FIFO entry.
//  T5 rst asserted for 1 cycle mid-stream
//   - All outputs return to reset values; no ren in the rst cycle.
//   - beat_cnt restarts from 0.
//  T6 CNT_WIDTH=4, 20 beats
//   - beat_cnt saturates at 15 and holds.
//  T7 (all tests) Assertion: fifo_ren & fifo_empty never true.

Source files
------------

// File: rtl/nx_fifo_drain.sv
// Read-side drain for nx_fifo: pulls show-ahead FIFO entries into a 2-entry
// registered buffer and presents them as a valid/ready stream at 1 beat/clk.
module nx_fifo_drain #(
    parameter int WIDTH     = 128,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_ren,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } occ_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    occ_t             state;
    occ_t             state_next;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e0_next;
    logic [WIDTH-1:0] e1_next;
    logic             push;
    logic             pop;

    // Request depends only on registered occupancy, never on out_ready.
    assign fifo_ren  = !rst && !flush && !fifo_empty && (state != S2);
    assign out_valid = (state != S0);
    assign out_data  = out_valid ? e0 : '0;
    assign occupancy = state;
    assign push      = fifo_ren;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        e0_next    = e0;
        e1_next    = e1;
        if (flush) begin
            state_next = S0;
        end else begin
            unique case (state)
                S0: begin
                    if (push) begin
                        e0_next    = fifo_rdata;
                        state_next = S1;
                    end
                end
                S1: begin
                    if (push && pop) begin
                        e0_next = fifo_rdata;
                    end else if (push) begin
                        e1_next    = fifo_rdata;
                        state_next = S2;
                    end else if (pop) begin
                        state_next = S0;
                    end
                end
                S2: begin
                    if (pop) begin
                        e0_next    = e1;
                        state_next = S1;
                    end
                end
                default: state_next = S0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the data entries are not reset; out_data is masked to zero whenever occupancy is 0.
    always_ff @(posedge clk) begin
        e0 <= e0_next;
        e1 <= e1_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_nx_fifo_drain.sv
// Directed bench for nx_fifo_drain: a queue stands in for nx_fifo, and a
// second instance with a 4-bit counter exercises saturation.
module tb_nx_fifo_drain;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_ren;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
    logic [15:0]  beat_cnt;

    logic         rst2;
    logic         fifo_ren2;
    logic         out_valid2;
    logic [W-1:0] out_data2;
    logic [1:0]   occupancy2;
    logic [3:0]   beat_cnt2;

    logic [W-1:0] q[$];
    logic [W-1:0] got[$];
    int           ren_total = 0;
    logic         ren_q = 1'b0;
    int           n_assert = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    nx_fifo_drain #(.WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .beat_cnt(beat_cnt)
    );

    nx_fifo_drain #(.WIDTH(W), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst2), .flush(1'b0),
        .fifo_empty(1'b0), .fifo_rdata(16'h0055), .fifo_ren(fifo_ren2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .occupancy(occupancy2), .beat_cnt(beat_cnt2)
    );

    // Edge-sampled history: which cycles requested a read, and which beats were delivered.
    always @(posedge clk) begin
        ren_q <= fifo_ren;
        if (fifo_ren) ren_total++;
        if (out_valid && out_ready && !flush && !rst) got.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic tick();
        #1;
        check("ren_while_empty", 32'(fifo_ren & fifo_empty), 32'h0);
        @(posedge clk);
        #1;
        if (ren_q) void'(q.pop_front());
        upd();
        #1;
    endtask

    task automatic push_fifo(input logic [W-1:0] v);
        q.push_back(v);
        upd();
    endtask

    initial begin
        int base_ren;
        int base_got;
        rst = 1'b1;
        rst2 = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        upd();
        tick();
        tick();

        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_cnt", 32'(beat_cnt), 32'h0);
        rst = 1'b0;

        // T1: three entries drain on consecutive clocks
        base_ren = ren_total;
        base_got = got.size();
        push_fifo(16'hA001);
        push_fifo(16'hA002);
        push_fifo(16'hA003);
        #1;
        check("t1_ren_first", 32'(fifo_ren), 32'h1);
        check("t1_valid_before", 32'(out_valid), 32'h0);
        tick();
        check("t1_valid_a", 32'(out_valid), 32'h1);
        check("t1_data_a", 32'(out_data), 32'hA001);
        check("t1_occ_a", 32'(occupancy), 32'h1);
        tick();
        check("t1_data_b", 32'(out_data), 32'hA002);
        check("t1_cnt_b", 32'(beat_cnt), 32'h1);
        tick();
        check("t1_data_c", 32'(out_data), 32'hA003);
        check("t1_occ_c", 32'(occupancy), 32'h1);
        tick();
        check("t1_valid_end", 32'(out_valid), 32'h0);
        check("t1_cnt", 32'(beat_cnt), 32'h3);
        check("t1_ren_count", 32'(ren_total - base_ren), 32'h3);
        check("t1_beats", 32'(got.size() - base_got), 32'h3);

        // T2: backpressure with four entries waiting
        out_ready = 1'b0;
        base_ren = ren_total;
        base_got = got.size();
        push_fifo(16'hB001);
        push_fifo(16'hB002);
        push_fifo(16'hB003);
        push_fifo(16'hB004);
        tick();
        check("t2_data_first", 32'(out_data), 32'hB001);
        tick();
        tick();
        check("t2_ren_count", 32'(ren_total - base_ren), 32'h2);
        check("t2_occ_full", 32'(occupancy), 32'h2);
        check("t2_data_held", 32'(out_data), 32'hB001);
        check("t2_no_ren_full", 32'(fifo_ren), 32'h0);
        out_ready = 1'b1;
        tick();
        check("t2_data_b", 32'(out_data), 32'hB002);
        tick();
        check("t2_data_c", 32'(out_data), 32'hB003);
        tick();
        check("t2_data_d", 32'(out_data), 32'hB004);
        tick();
        check("t2_valid_end", 32'(out_valid), 32'h0);
        check("t2_cnt", 32'(beat_cnt), 32'h7);
        for (int k = 0; k < 4; k++) check("t2_order", 32'(got[base_got + k]), 32'hB001 + k);

        // T3: alternating out_ready over eight entries
        base_got = got.size();
        for (int k = 0; k < 8; k++) push_fifo(16'h3000 + 16'(k));
        for (int i = 0; i < 24; i++) begin
            logic         held;
            logic [W-1:0] prev;
            out_ready = i[0];
            #1;
            held = out_valid && !out_ready;
            prev = out_data;
            tick();
            if (held) check("t3_stable", 32'(out_data), 32'(prev));
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("t3_beats", 32'(got.size() - base_got), 32'h8);
        for (int k = 0; k < 8; k++) check("t3_order", 32'(got[base_got + k]), 32'h3000 + k);
        check("t3_cnt", 32'(beat_cnt), 32'hF);

        // T4: flush with a full buffer and a non-empty fifo
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_fifo(16'h4000 + 16'(k));
        tick();
        tick();
        tick();
        check("t4_occ_full", 32'(occupancy), 32'h2);
        flush = 1'b1;
        out_ready = 1'b1;
        base_got = got.size();
        #1;
        check("t4_no_ren_flush", 32'(fifo_ren), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        check("t4_valid", 32'(out_valid), 32'h0);
        check("t4_occ", 32'(occupancy), 32'h0);
        check("t4_data", 32'(out_data), 32'h0);
        check("t4_cnt_kept", 32'(beat_cnt), 32'hF);
        tick();
        check("t4_resume", 32'(out_data), 32'h4002);
        tick();
        check("t4_resume_next", 32'(out_data), 32'h4003);
        tick();
        check("t4_cnt", 32'(beat_cnt), 32'h11);
        check("t4_beats", 32'(got.size() - base_got), 32'h2);

        // T5: one-cycle reset mid-stream
        for (int k = 0; k < 4; k++) push_fifo(16'h5000 + 16'(k));
        tick();
        tick();
        check("t5_pre_data", 32'(out_data), 32'h5001);
        check("t5_pre_cnt", 32'(beat_cnt), 32'h12);
        rst = 1'b1;
        #1;
        check("t5_no_ren_rst", 32'(fifo_ren), 32'h0);
        tick();
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_occ", 32'(occupancy), 32'h0);
        check("t5_data", 32'(out_data), 32'h0);
        check("t5_cnt", 32'(beat_cnt), 32'h0);
        rst = 1'b0;
        tick();
        check("t5_resume", 32'(out_data), 32'h5002);
        tick();
        check("t5_resume_next", 32'(out_data), 32'h5003);
        tick();
        check("t5_cnt_restart", 32'(beat_cnt), 32'h2);

        // T6: 4-bit counter saturation on the second instance
        rst2 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_cnt_mid", 32'(beat_cnt2), 32'h9);
        check("t6_occ", 32'(occupancy2), 32'h1);
        for (int i = 0; i < 15; i++) tick();
        check("t6_cnt_sat", 32'(beat_cnt2), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        check("t6_cnt_hold", 32'(beat_cnt2), 32'hF);
        check("t6_valid", 32'(out_valid2), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
